// File: rtl/sar_pkg.sv
// Shared types for the SAR search block: FSM state encoding and default operand width.
package sar_pkg;
   localparam int SAR_N_DEFAULT = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRIAL = 2'd1,
      DONE  = 2'd2
   } sar_state_e;
endpackage

// File: rtl/sar_onehot_chk.sv
// Flags a three-bit comparator flag vector that is not exactly one-hot.
module sar_onehot_chk (
   input  logic [2:0] flags_i,
   output logic       bad_o
);
   always_comb begin
      case (flags_i)
         3'b001, 3'b010, 3'b100: bad_o = 1'b0;
         default:                bad_o = 1'b1;
      endcase
   end
endmodule

// File: rtl/sar_search_32bit.sv
// Successive-approximation search against an external comparator, MSB first.
// Optional SAR_SEARCH_EARLY_EXIT_EN: finish as soon as the comparator reports equality.
module sar_search_32bit
   import sar_pkg::*;
#(
   parameter int N = SAR_N_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   output logic [N-1:0] guess,
   input  logic         cmp_g,
   input  logic         cmp_e,
   input  logic         cmp_l,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result,
   output logic         found,
   output logic         err,
   output sar_state_e   state_dbg
);
   localparam int              IDXW    = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDXW-1:0] IDX_MAX = IDXW'(N - 1);
   localparam logic [N-1:0]    MSB_ONE = {1'b1, {(N-1){1'b0}}};

`ifdef SAR_SEARCH_EARLY_EXIT_EN
   localparam bit EARLY_EXIT = 1'b1;
`else
   localparam bit EARLY_EXIT = 1'b0;
`endif

   sar_state_e      state_q;
   logic [N-1:0]    guess_q;
   logic [N-1:0]    guess_d;
   logic [IDXW-1:0] idx_q;
   logic [N-1:0]    result_q;
   logic            found_q;
   logic            err_q;
   logic            flags_bad;

   sar_onehot_chk u_onehot_chk (
      .flags_i ({cmp_g, cmp_e, cmp_l}),
      .bad_o   (flags_bad)
   );

   // Resolve the bit under test, then tentatively set the next lower bit.
   always_comb begin
      guess_d = guess_q;
      if (cmp_l) guess_d[idx_q] = 1'b0;
      if (idx_q != '0) guess_d[idx_q - 1'b1] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         guess_q  <= '0;
         idx_q    <= '0;
         result_q <= '0;
         found_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= TRIAL;
                  guess_q <= MSB_ONE;
                  idx_q   <= IDX_MAX;
                  found_q <= 1'b0;
                  err_q   <= 1'b0;
               end
            end
            TRIAL: begin
               if (flags_bad) begin
                  err_q   <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  if (cmp_e) found_q <= 1'b1;
                  if (EARLY_EXIT && cmp_e) begin
                     result_q <= guess_q;
                     state_q  <= DONE;
                  end else if (idx_q == '0) begin
                     guess_q  <= guess_d;
                     result_q <= guess_d;
                     state_q  <= DONE;
                  end else begin
                     guess_q <= guess_d;
                     idx_q   <= idx_q - 1'b1;
                  end
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign guess     = guess_q;
   assign result    = result_q;
   assign found     = found_q;
   assign err       = err_q;
   assign busy      = (state_q == TRIAL);
   assign done      = (state_q == DONE);
   assign state_dbg = state_q;
endmodule

// File: doc/sar_search_32bit.md
SAR_SEARCH_32BIT -- requirements
Module: sar_search_32bit

Interface
REQ-001 SHALL have parameter N, default 32, operand/guess width in bits.
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request a new search; sampled only in IDLE.
REQ-005 SHALL have port guess  output  N  trial value driven to the external magnitude comparator (target vs guess).
REQ-006 SHALL have port cmp_g  input  1  comparator flag, target > guess, same-cycle combinational response to guess.
REQ-007 SHALL have port cmp_e  input  1  comparator flag, target == guess.
REQ-008 SHALL have port cmp_l  input  1  comparator flag, target < guess.
REQ-009 SHALL have port busy  output  1  high while in TRIAL.
REQ-010 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port result  output  N  recovered target value, held until next start.
REQ-012 SHALL have port found  output  1  high with result if cmp_e was observed during the search.
REQ-013 SHALL have port err  output  1  sticky, flags not one-hot during TRIAL.

Function
REQ-014 SHALL implement states IDLE, TRIAL, DONE; IDLE->TRIAL on start, TRIAL->DONE on last bit or early exit, TRIAL->IDLE on error, DONE->IDLE unconditionally.
REQ-015 SHALL, on start accepted in IDLE, load guess = 1<<(N-1), bit index = N-1, clear found/err, assert busy next cycle.
REQ-016 SHALL, each TRIAL cycle, sample flags against current guess: cmp_l clears bit[idx]; cmp_g or cmp_e keeps bit[idx].
REQ-017 SHALL, if idx > 0, set bit[idx-1] in guess for the next cycle and decrement idx; if idx == 0, go to DONE.
REQ-018 SHALL set found when cmp_e is sampled high in any TRIAL cycle.
REQ-019 SHALL, without early exit, take exactly N TRIAL cycles; done asserts in the cycle after the last TRIAL cycle (N+1 cycles after start sampled).
REQ-020 SHALL, in DONE, drive result = final guess, pulse done for one cycle, and hold result/found until next accepted start.
REQ-021 SHALL ignore start while in TRIAL or DONE; no queuing.
REQ-022 SHALL, if {cmp_g,cmp_e,cmp_l} is not exactly one-hot in TRIAL, set err, return to IDLE next cycle, and not pulse done.
REQ-023 SHALL hold guess at its last value in IDLE and DONE.
REQ-024 SHALL produce result = target for any target in 0..2^N-1, including 0 (all bits cleared) and 2^N-1 (all bits kept).

Reset
REQ-025 SHALL, on rst_n low at any time including mid-search, asynchronously force state IDLE, guess = 0, result = 0, busy = 0, done = 0, found = 0, err = 0.
REQ-026 SHALL accept start in the first clock edge after rst_n deasserts.

Configuration
REQ-027 SHALL, with SAR_SEARCH_EARLY_EXIT_EN defined, go to DONE in the cycle after cmp_e is sampled, with result = current guess and found = 1.
REQ-028 SHALL, without SAR_SEARCH_EARLY_EXIT_EN, always run all N TRIAL cycles regardless of cmp_e.

Structure
REQ-029 SHALL place the state enum typedef and default width constant in shared package sar_pkg.
REQ-030 SHALL use one sub-module, sar_onehot_chk, which flags a non-one-hot three-flag vector.
REQ-031 SHALL keep the comparator external; the bench and integrating logic instantiate it.

Verification
REQ-032 SHALL cover: target 0xA5A5_5A5A, no macro -> done at cycle 33 after start, result 0xA5A5_5A5A, found 1.
REQ-033 SHALL cover: target 0x8000_0000 with SAR_SEARCH_EARLY_EXIT_EN -> done one cycle after first TRIAL, result 0x8000_0000, found 1.
REQ-034 SHALL cover: targets 0x0000_0000 and 0xFFFF_FFFF -> result equals target, 32 TRIAL cycles each without macro.
REQ-035 SHALL cover: force cmp_g and cmp_l both high at TRIAL cycle 5 -> err 1, return to IDLE, no done pulse.
REQ-036 SHALL cover: rst_n low at TRIAL cycle 10 -> all outputs 0 immediately; new start after release completes correctly.
REQ-037 SHALL cover: start pulsed during TRIAL and DONE -> ignored; single done per accepted start.
